id_ex_stage: RTL and testbench

- ID→EX pipeline register sitting directly upstream of the execute ALU.
- Captures decoded instruction fields and resolves both operands with bypass from EX (live ALU result), MEM and WB.
- Detects load-use hazards and stalls decode.
- Drives alu_op / alu_src1 / alu_src2 straight into the ALU, using a valid/ready handshake on both sides.

---
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: handshake and data bundle around the ID->EX register.
// Ports: decode side (id_*), bypass sources (ex/mem/wb), flush, EX side.
interface id_ex_stage_if #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 5,
    parameter int REG_ADDR_W   = 5
);
    logic                    id_valid;
    logic                    id_ready;
    logic [ALU_OP_WIDTH-1:0] id_alu_op;
    logic [XLEN-1:0]         id_pc;
    logic [XLEN-1:0]         id_imm;
    logic [REG_ADDR_W-1:0]   id_rs1_addr;
    logic [REG_ADDR_W-1:0]   id_rs2_addr;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic [XLEN-1:0]         id_rs1_data;
    logic [XLEN-1:0]         id_rs2_data;
    logic                    id_src1_sel;
    logic                    id_src2_sel;
    logic [REG_ADDR_W-1:0]   id_rd_addr;
    logic                    id_rd_wen;
    logic                    id_is_load;
    logic [XLEN-1:0]         ex_alu_res;
    logic [REG_ADDR_W-1:0]   mem_rd_addr;
    logic                    mem_rd_wen;
    logic [XLEN-1:0]         mem_rd_data;
    logic [REG_ADDR_W-1:0]   wb_rd_addr;
    logic                    wb_rd_wen;
    logic [XLEN-1:0]         wb_rd_data;
    logic                    flush;
    logic                    ex_ready;
    logic                    ex_valid;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [XLEN-1:0]         alu_src1;
    logic [XLEN-1:0]         alu_src2;
    logic [XLEN-1:0]         ex_store_data;
    logic [XLEN-1:0]         ex_pc;
    logic [XLEN-1:0]         ex_imm;
    logic [REG_ADDR_W-1:0]   ex_rd_addr;
    logic                    ex_rd_wen;
    logic                    ex_is_load;

    modport master (
        output id_valid, id_alu_op, id_pc, id_imm,
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output id_rs1_data, id_rs2_data, id_src1_sel, id_src2_sel,
        output id_rd_addr, id_rd_wen, id_is_load, ex_alu_res,
        output mem_rd_addr, mem_rd_wen, mem_rd_data,
        output wb_rd_addr, wb_rd_wen, wb_rd_data, flush, ex_ready,
        input  id_ready, ex_valid, alu_op, alu_src1, alu_src2,
        input  ex_store_data, ex_pc, ex_imm, ex_rd_addr,
        input  ex_rd_wen, ex_is_load
    );

    modport slave (
        input  id_valid, id_alu_op, id_pc, id_imm,
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  id_rs1_data, id_rs2_data, id_src1_sel, id_src2_sel,
        input  id_rd_addr, id_rd_wen, id_is_load, ex_alu_res,
        input  mem_rd_addr, mem_rd_wen, mem_rd_data,
        input  wb_rd_addr, wb_rd_wen, wb_rd_data, flush, ex_ready,
        output id_ready, ex_valid, alu_op, alu_src1, alu_src2,
        output ex_store_data, ex_pc, ex_imm, ex_rd_addr,
        output ex_rd_wen, ex_is_load
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX register with EX/MEM/WB bypass and load-use stall.
// Ports: clk, rst (async high), bus (slave), stall_cnt if ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 5,
    parameter int REG_ADDR_W   = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
   ,output logic [31:0]  stall_cnt
`endif
);
    logic                    r_valid;
    logic [ALU_OP_WIDTH-1:0] r_alu_op;
    logic [XLEN-1:0]         r_src1;
    logic [XLEN-1:0]         r_src2;
    logic [XLEN-1:0]         r_store;
    logic [XLEN-1:0]         r_pc;
    logic [XLEN-1:0]         r_imm;
    logic [REG_ADDR_W-1:0]   r_rd_addr;
    logic                    r_rd_wen;
    logic                    r_is_load;

    logic            w_hazard;
    logic            w_fire_in;
    logic            w_fire_out;
    logic            w_ex_hit;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    // A held load cannot bypass; its consumer waits one bubble for MEM.
    assign w_hazard = r_valid && r_is_load && r_rd_wen
                   && (r_rd_addr != '0)
                   && ((bus.id_rs1_used && bus.id_rs1_addr == r_rd_addr)
                    || (bus.id_rs2_used && bus.id_rs2_addr == r_rd_addr));

    assign w_fire_out = r_valid && bus.ex_ready;
    assign bus.id_ready = (!r_valid || bus.ex_ready) && !w_hazard;
    assign w_fire_in = bus.id_valid && bus.id_ready;

    // The live ALU result is only usable when its entry leaves this cycle.
    assign w_ex_hit = r_valid && w_fire_out && r_rd_wen && !r_is_load;

    always_comb begin
        w_rs1_fwd = bus.id_rs1_data;
        if (bus.id_rs1_addr == '0)
            w_rs1_fwd = '0;
        else if (w_ex_hit && bus.id_rs1_addr == r_rd_addr)
            w_rs1_fwd = bus.ex_alu_res;
        else if (bus.mem_rd_wen && bus.id_rs1_addr == bus.mem_rd_addr)
            w_rs1_fwd = bus.mem_rd_data;
        else if (bus.wb_rd_wen && bus.id_rs1_addr == bus.wb_rd_addr)
            w_rs1_fwd = bus.wb_rd_data;
    end

    always_comb begin
        w_rs2_fwd = bus.id_rs2_data;
        if (bus.id_rs2_addr == '0)
            w_rs2_fwd = '0;
        else if (w_ex_hit && bus.id_rs2_addr == r_rd_addr)
            w_rs2_fwd = bus.ex_alu_res;
        else if (bus.mem_rd_wen && bus.id_rs2_addr == bus.mem_rd_addr)
            w_rs2_fwd = bus.mem_rd_data;
        else if (bus.wb_rd_wen && bus.id_rs2_addr == bus.wb_rd_addr)
            w_rs2_fwd = bus.wb_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_store   <= '0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_rd_addr <= '0;
            r_rd_wen  <= 1'b0;
            r_is_load <= 1'b0;
        end else if (bus.flush) begin
            r_valid  <= 1'b0;
            r_rd_wen <= 1'b0;
        end else if (w_fire_in) begin
            r_valid   <= 1'b1;
            r_alu_op  <= bus.id_alu_op;
            r_src1    <= bus.id_src1_sel ? bus.id_pc : w_rs1_fwd;
            r_src2    <= bus.id_src2_sel ? bus.id_imm : w_rs2_fwd;
            r_store   <= w_rs2_fwd;
            r_pc      <= bus.id_pc;
            r_imm     <= bus.id_imm;
            r_rd_addr <= bus.id_rd_addr;
            r_rd_wen  <= bus.id_rd_wen;
            r_is_load <= bus.id_is_load;
        end else if (w_fire_out) begin
            r_valid   <= 1'b0;
            r_alu_op  <= '0;
            r_rd_wen  <= 1'b0;
            r_is_load <= 1'b0;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.alu_op        = r_alu_op;
    assign bus.alu_src1      = r_src1;
    assign bus.alu_src2      = r_src2;
    assign bus.ex_store_data = r_store;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_rd_wen     = r_rd_wen;
    assign bus.ex_is_load    = r_is_load;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (bus.id_valid && w_hazard && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus with a queue scoreboard
// checked by a monitor on every accepted EX entry.
module tb_id_ex_stage;
    logic clk;
    logic rst;

    id_ex_stage_if bus ();

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ID_EX_STALL_CNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] st;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (!rst && bus.ex_valid && bus.ex_ready && !bus.flush) begin
            a = '{bus.alu_op, bus.alu_src1, bus.alu_src2,
                  bus.ex_store_data, bus.ex_pc, bus.ex_imm,
                  bus.ex_rd_addr, bus.ex_rd_wen, bus.ex_is_load};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry actual=%h required=none", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL entry actual=%h required=%h", a, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
        input logic [4:0] a1, input logic u1, input logic [31:0] d1,
        input logic [4:0] a2, input logic u2, input logic [31:0] d2,
        input logic s1, input logic s2,
        input logic [4:0] rd, input logic wen, input logic ld);
        bus.id_valid    = 1'b1;
        bus.id_alu_op   = op;
        bus.id_pc       = pc;
        bus.id_imm      = imm;
        bus.id_rs1_addr = a1;
        bus.id_rs1_used = u1;
        bus.id_rs1_data = d1;
        bus.id_rs2_addr = a2;
        bus.id_rs2_used = u2;
        bus.id_rs2_data = d2;
        bus.id_src1_sel = s1;
        bus.id_src2_sel = s2;
        bus.id_rd_addr  = rd;
        bus.id_rd_wen   = wen;
        bus.id_is_load  = ld;
    endtask

    task automatic set_mem(input logic [4:0] a, input logic w,
                           input logic [31:0] d);
        bus.mem_rd_addr = a;
        bus.mem_rd_wen  = w;
        bus.mem_rd_data = d;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic w,
                          input logic [31:0] d);
        bus.wb_rd_addr = a;
        bus.wb_rd_wen  = w;
        bus.wb_rd_data = d;
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0;
        drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0,
              5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        bus.id_valid   = 1'b0;
        bus.ex_alu_res = 32'd0;
        set_mem(5'd0, 1'b0, 32'd0);
        set_wb(5'd0, 1'b0, 32'd0);
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        #1;
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_alu_op", {27'd0, bus.alu_op}, 32'd0);
        chk("rst_src1", bus.alu_src1, 32'd0);
        chk("rst_store", bus.ex_store_data, 32'd0);
        #11;
        rst = 1'b0;
        step();

        // add x3 = x1(5) + x2(7)
        drive(5'd1, 32'h100, 32'd0, 5'd1, 1'b1, 32'd5,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("add_id_ready", {31'd0, bus.id_ready}, 32'd1);
        q.push_back('{5'd1, 32'd5, 32'd7, 32'd7, 32'h100, 32'd0,
                      5'd3, 1'b1, 1'b0});
        step();
        chk("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

        // sub x4 = x3 - x2, EX result beats MEM
        bus.ex_alu_res = 32'd12;
        set_mem(5'd3, 1'b1, 32'd99);
        drive(5'd2, 32'h104, 32'd0, 5'd3, 1'b1, 32'd0,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        chk("sub_id_ready", {31'd0, bus.id_ready}, 32'd1);
        q.push_back('{5'd2, 32'd12, 32'd7, 32'd7, 32'h104, 32'd0,
                      5'd4, 1'b1, 1'b0});
        step();

        // lw x5, 8(x1)
        set_mem(5'd0, 1'b0, 32'd0);
        bus.ex_alu_res = 32'd5;
        drive(5'd1, 32'h108, 32'd8, 5'd1, 1'b1, 32'd5,
              5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        q.push_back('{5'd1, 32'd5, 32'd8, 32'd0, 32'h108, 32'd8,
                      5'd5, 1'b1, 1'b1});
        step();

        // and x6 = x5 & x2 -> load-use stall
        bus.ex_alu_res = 32'h110;
        drive(5'd3, 32'h10c, 32'd0, 5'd5, 1'b1, 32'd0,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("hazard_id_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        chk("bubble_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("bubble_alu_op", {27'd0, bus.alu_op}, 32'd0);
        chk("bubble_is_load", {31'd0, bus.ex_is_load}, 32'd0);
        set_mem(5'd5, 1'b1, 32'hDEAD);
        #1;
        chk("after_bubble_id_ready", {31'd0, bus.id_ready}, 32'd1);
        q.push_back('{5'd3, 32'hDEAD, 32'd7, 32'd7, 32'h10c, 32'd0,
                      5'd6, 1'b1, 1'b0});
        step();
        chk("and_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd1);
`endif

        // EX back-pressure for 3 cycles
        set_mem(5'd0, 1'b0, 32'd0);
        bus.ex_ready = 1'b0;
        bus.ex_alu_res = 32'd7;
        drive(5'd4, 32'h110, 32'd0, 5'd1, 1'b1, 32'd5,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_id_ready", {31'd0, bus.id_ready}, 32'd0);
            chk("hold_alu_op", {27'd0, bus.alu_op}, 32'd3);
            chk("hold_src1", bus.alu_src1, 32'hDEAD);
            step();
        end
        bus.ex_ready = 1'b1;
        step();

        // flush squashes held "or" and the incoming xor
        drive(5'd5, 32'h114, 32'd0, 5'd1, 1'b1, 32'd5,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_id_ready", {31'd0, bus.id_ready}, 32'd1);
        step();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_rd_wen", {31'd0, bus.ex_rd_wen}, 32'd0);

        // x0 sources resolve to 0 despite MEM/WB/regfile
        set_wb(5'd0, 1'b1, 32'h55);
        set_mem(5'd0, 1'b1, 32'h66);
        drive(5'd6, 32'h120, 32'd0, 5'd0, 1'b1, 32'h77,
              5'd0, 1'b1, 32'h77, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        q.push_back('{5'd6, 32'd0, 32'd0, 32'd0, 32'h120, 32'd0,
                      5'd0, 1'b1, 1'b0});
        step();

        // pc/imm select; store data takes MEM over WB
        bus.ex_alu_res = 32'h99;
        set_mem(5'd9, 1'b1, 32'hAAAA);
        set_wb(5'd9, 1'b1, 32'hBBBB);
        drive(5'd7, 32'h200, 32'h40, 5'd0, 1'b1, 32'd0,
              5'd9, 1'b1, 32'h1234, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        q.push_back('{5'd7, 32'h200, 32'h40, 32'hAAAA, 32'h200, 32'h40,
                      5'd9, 1'b1, 1'b0});
        step();

        // WB-only bypass on rs1, EX bypass on rs2
        bus.ex_alu_res = 32'h240;
        set_mem(5'd0, 1'b0, 32'd0);
        set_wb(5'd10, 1'b1, 32'hCCCC);
        drive(5'd8, 32'h204, 32'd0, 5'd10, 1'b1, 32'd1,
              5'd9, 1'b1, 32'h1234, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        q.push_back('{5'd8, 32'hCCCC, 32'h240, 32'h240, 32'h204, 32'd0,
                      5'd11, 1'b1, 1'b0});
        step();

        // op9 is captured and then lost to an async reset
        set_wb(5'd0, 1'b0, 32'd0);
        drive(5'd9, 32'h208, 32'd0, 5'd1, 1'b1, 32'd5,
              5'd2, 1'b1, 32'd7, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        step();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        step();
        chk("held_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("async_rst_alu_op", {27'd0, bus.alu_op}, 32'd0);
        chk("async_rst_rd_wen", {31'd0, bus.ex_rd_wen}, 32'd0);
        chk("async_rst_src1", bus.alu_src1, 32'd0);
        chk("queue_empty", q.size(), 32'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
